// File: rtl/engine_clause_queue_if.sv
// Handshake bundle between the clause distribution unit, a per-engine clause
// queue and the BCP engine that drains it.
interface engine_clause_queue_if #(
  parameter int CW   = 33,
  parameter int CNTW = 4
);
  logic            push_in;
  logic [CW-1:0]   clause_in;
  logic            pop_in;
  logic            flush_in;
  logic [CW-1:0]   clause_out;
  logic            valid_out;
  logic            full_out;
  logic            empty_out;
  logic [CNTW-1:0] count_out;
  logic            error_out;

  // The producer/consumer side drives the strobes and observes the status.
  modport master (
    output push_in, clause_in, pop_in, flush_in,
    input  clause_out, valid_out, full_out, empty_out, count_out, error_out
  );

  modport slave (
    input  push_in, clause_in, pop_in, flush_in,
    output clause_out, valid_out, full_out, empty_out, count_out, error_out
  );
endinterface

// File: rtl/engine_clause_queue.sv
// Show-ahead circular clause queue feeding one BCP engine; flags decode only
// from registered pointer/count state, with a sticky over/underflow error bit.
module engine_clause_queue #(
  parameter int LIT_IDX_MAX = 1024,
  parameter int CLA_LENGTH  = 3,
  parameter int DEPTH       = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  engine_clause_queue_if.slave q
);
  localparam int VARIABLE_LENGTH = $clog2(LIT_IDX_MAX) + 1;
  localparam int CW              = CLA_LENGTH * VARIABLE_LENGTH;
  localparam int PTRW            = $clog2(DEPTH);
  localparam int CNTW            = PTRW + 1;
  localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(DEPTH);
  localparam logic [PTRW-1:0] PTR_ONE    = PTRW'(1);
  localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(1);

  logic [CW-1:0]   mem_q [DEPTH];
  logic [PTRW-1:0] wrPtr_q, wrPtr_d;
  logic [PTRW-1:0] rdPtr_q, rdPtr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            error_q, error_d;

  logic isFull, isEmpty;
  logic pushAcc, popAcc;

  assign isFull  = (count_q == FULL_COUNT);
  assign isEmpty = (count_q == '0);

  // A push into a full queue is only legal when the head leaves in the same
  // cycle; a pop of an empty queue never happens. Flush overrides both.
  assign pushAcc = q.push_in & ~q.flush_in & (~isFull | q.pop_in);
  assign popAcc  = q.pop_in  & ~q.flush_in & ~isEmpty;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    error_d = error_q;
    if (q.flush_in) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
      error_d = 1'b0;
    end else begin
      if (pushAcc) wrPtr_d = wrPtr_q + PTR_ONE;
      if (popAcc)  rdPtr_d = rdPtr_q + PTR_ONE;
      if (pushAcc && !popAcc)      count_d = count_q + CNT_ONE;
      else if (popAcc && !pushAcc) count_d = count_q - CNT_ONE;
      if ((q.push_in && isFull && !q.pop_in) || (q.pop_in && isEmpty))
        error_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  // Storage is never cleared; visibility is governed purely by the pointers.
  always_ff @(posedge clock) begin
    if (pushAcc) mem_q[wrPtr_q] <= q.clause_in;
  end

  assign q.clause_out = isEmpty ? '0 : mem_q[rdPtr_q];
  assign q.valid_out  = ~isEmpty;
  assign q.full_out   = isFull;
  assign q.empty_out  = isEmpty;
  assign q.count_out  = count_q;
  assign q.error_out  = error_q;
endmodule

// File: tb/tb_engine_clause_queue.sv
// Self-checking bench for engine_clause_queue: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_engine_clause_queue;
  localparam int DEPTH = 8;
  localparam int CW    = 33;
  localparam int CNTW  = 4;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  logic [CW-1:0] model[$];
  logic          modelErr;

  engine_clause_queue_if #(.CW(CW), .CNTW(CNTW)) bus ();

  engine_clause_queue #(
    .LIT_IDX_MAX(1024),
    .CLA_LENGTH (3),
    .DEPTH      (DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .q    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares every status output against what the model says should be visible.
  task automatic checkOutput(input string tag);
    logic [CW-1:0] expHead;
    int            n;
    n       = model.size();
    expHead = (n > 0) ? model[0] : '0;
    checkVal({tag, ".count"}, 64'(bus.count_out), 64'(n));
    checkVal({tag, ".full"},  64'(bus.full_out),  64'(n == DEPTH));
    checkVal({tag, ".empty"}, 64'(bus.empty_out), 64'(n == 0));
    checkVal({tag, ".valid"}, 64'(bus.valid_out), 64'(n != 0));
    checkVal({tag, ".head"},  64'(bus.clause_out), 64'(expHead));
    checkVal({tag, ".error"}, 64'(bus.error_out), 64'(modelErr));
  endtask

  // Drives one cycle of stimulus, advances the model at the edge, then checks.
  task automatic applyStimulus(input logic push, input logic pop, input logic flush,
                               input logic [CW-1:0] clause, input string tag);
    bit wasEmpty, wasFull;
    bus.push_in   = push;
    bus.pop_in    = pop;
    bus.flush_in  = flush;
    bus.clause_in = clause;
    @(posedge clock);
    wasEmpty = (model.size() == 0);
    wasFull  = (model.size() == DEPTH);
    if (flush) begin
      model.delete();
      modelErr = 1'b0;
    end else begin
      if (pop && wasEmpty) modelErr = 1'b1;
      if (push && wasFull && !pop) modelErr = 1'b1;
      if (pop && !wasEmpty) void'(model.pop_front());
      if (push && (!wasFull || pop)) model.push_back(clause);
    end
    #1;
    bus.push_in  = 1'b0;
    bus.pop_in   = 1'b0;
    bus.flush_in = 1'b0;
    checkOutput(tag);
  endtask

  initial begin
    logic [CW-1:0] c;
    total = 0;
    bad   = 0;
    modelErr      = 1'b0;
    reset         = 1'b0;
    bus.push_in   = 1'b0;
    bus.pop_in    = 1'b0;
    bus.flush_in  = 1'b0;
    bus.clause_in = '0;
    #2;
    checkOutput("reset");
    @(negedge clock);
    reset = 1'b1;

    for (int i = 1; i <= 8; i++) applyStimulus(1, 0, 0, CW'(i), "fill");
    checkVal("fill.fullCount", 64'(bus.count_out), 64'd8);
    checkVal("fill.head1", 64'(bus.clause_out), 64'd1);

    applyStimulus(1, 0, 0, CW'(9), "overflow");
    checkVal("overflow.err", 64'(bus.error_out), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      checkVal("drain.order", 64'(bus.clause_out), 64'(i));
      applyStimulus(0, 1, 0, '0, "drain");
    end
    checkVal("drain.empty", 64'(bus.empty_out), 64'd1);

    applyStimulus(0, 1, 0, '0, "underflow");
    applyStimulus(1, 1, 0, CW'(42), "emptyPushPop");
    checkVal("emptyPushPop.count", 64'(bus.count_out), 64'd1);

    applyStimulus(0, 0, 1, '0, "flushA");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, CW'(100 + i), "pre3");
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, CW'(200 + i), "steady3");
    checkVal("steady3.head", 64'(bus.clause_out), 64'd207);

    applyStimulus(0, 0, 1, '0, "flushB");
    for (int i = 1; i <= 8; i++) applyStimulus(1, 0, 0, CW'(i), "refill");
    applyStimulus(1, 1, 0, CW'(20), "fullPushPop");
    checkVal("fullPushPop.head2", 64'(bus.clause_out), 64'd2);
    checkVal("fullPushPop.noErr", 64'(bus.error_out), 64'd0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, '0, "drainTo20");

    applyStimulus(0, 0, 1, '0, "flushC");
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, CW'(50 + i), "pre5");
    applyStimulus(1, 0, 1, CW'(99), "flushPush");
    checkVal("flushPush.empty", 64'(bus.empty_out), 64'd1);

    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, CW'(60 + i), "pre4");
    reset = 1'b0;
    model.delete();
    modelErr = 1'b0;
    #2;
    checkOutput("asyncReset");
    #1;
    reset = 1'b1;
    applyStimulus(1, 0, 0, CW'(7), "postReset");
    checkVal("postReset.head7", 64'(bus.clause_out), 64'd7);

    for (int i = 0; i < 400; i++) begin
      int pushPct, popPct;
      pushPct = ((i / 50) % 2 == 0) ? 75 : 30;
      popPct  = ((i / 50) % 2 == 0) ? 30 : 75;
      c = CW'({$urandom(), $urandom()});
      applyStimulus($urandom_range(99, 0) < pushPct,
                    $urandom_range(99, 0) < popPct,
                    $urandom_range(63, 0) == 0, c, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/engine_clause_queue.md
ENGINE_CLAUSE_QUEUE -- requirements
Module: engine_clause_queue

Interface
REQ-001 Parameter LIT_IDX_MAX, default 1024, max literal index; VARIABLE_LENGTH = clog2(LIT_IDX_MAX)+1 = 11.
REQ-002 Parameter CLA_LENGTH, default 3, literals per clause; clause width CW = CLA_LENGTH*VARIABLE_LENGTH = 33.
REQ-003 Parameter DEPTH, default 8, power of two >= 2; entry count.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low; reset = 0 forces the reset state immediately.
REQ-006 push_in  input  1  write strobe; driven by one grant_out bit of the distribution unit.
REQ-007 clause_in  input  CW  clause written when push_in = 1; driven by the matching clause_out slice.
REQ-008 pop_in  input  1  BCP engine consumes the head entry.
REQ-009 flush_in  input  1  discard all stored clauses (engine restart/backtrack).
REQ-010 clause_out  output  CW  head entry (show-ahead).
REQ-011 valid_out  output  1  clause_out holds a stored clause.
REQ-012 full_out  output  1  no free entry; drives the matching full_in bit of the distribution unit.
REQ-013 empty_out  output  1  no stored entry.
REQ-014 count_out  output  clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-015 error_out  output  1  sticky: overflow or underflow occurred since reset/flush.

Function
REQ-016 Storage SHALL be a circular buffer with write pointer, read pointer and occupancy counter; pointers wrap from DEPTH-1 to 0.
REQ-017 full_out, empty_out, valid_out, count_out SHALL be decoded from registered state only, no input-to-output combinational path.
REQ-018 full_out = (count == DEPTH); empty_out = (count == 0); valid_out = ~empty_out.
REQ-019 clause_out SHALL equal the entry at the read pointer; when empty it SHALL be all zeros.
REQ-020 Accepted push: entry written at write pointer, pointer +1, count +1, visible on clause_out the next cycle if the queue was empty (latency 1, no bypass).
REQ-021 Accepted pop: read pointer +1, count -1; next entry appears on clause_out the following cycle.
REQ-022 Push while full with no pop SHALL be dropped: no state change except error_out set.
REQ-023 Pop while empty SHALL be ignored except error_out set.
REQ-024 Push and pop same cycle, 0 < count < DEPTH: both performed, count unchanged.
REQ-025 Push and pop same cycle while full: both performed, count stays DEPTH, no error.
REQ-026 Push and pop same cycle while empty: push accepted, pop ignored, error_out set, count becomes 1.
REQ-027 flush_in = 1 SHALL take priority over push_in/pop_in: next cycle pointers = 0, count = 0, error_out = 0; concurrent push discarded.
REQ-028 Storage contents need not be cleared by flush or reset; only pointers/count control visibility.

Reset
REQ-029 While reset = 0: read/write pointers 0, count_out = 0, empty_out = 1, full_out = 0, valid_out = 0, clause_out = 0, error_out = 0.
REQ-030 Reset asserted mid-operation SHALL discard all entries asynchronously; operation resumes on the first rising edge after reset returns to 1.

Verification
REQ-031 Reset, push clauses 1..8 on consecutive cycles, no pop -> count_out 8, full_out 1 after 8th edge, clause_out = 1, error_out 0.
REQ-032 From full, push 9 without pop -> count stays 8, error_out 1; then pop 8 times -> clause_out sequence 1..8, empty_out 1.
REQ-033 Count 3, push and pop together for 10 cycles -> count_out stays 3, FIFO order preserved across pointer wrap.
REQ-034 Full queue, push 20 with pop same cycle -> count 8, no error, head advances to 2, 20 emerges last.
REQ-035 Count 5, assert flush_in with push_in = 1 -> next cycle count 0, empty_out 1, error_out 0, pushed clause lost.
REQ-036 Count 4, drive reset = 0 between edges -> outputs reach reset values without a clock edge; after release, push 7 -> clause_out = 7, count 1.
